// File: rtl/keccak_arbiter.sv
// keccak_arbiter: round-robin owner of one keccak core across NUM_REQ message sources; KECCAK_ARB_TIMEOUT_EN adds an idle-absorb watchdog with Abort
module keccak_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int WORDS_PER_BLOCK = 17,
  parameter int DIGEST_BEATS = 4,
`ifdef KECCAK_ARB_TIMEOUT_EN
  parameter int TIMEOUT_CYCLES = 1024,
`endif
  localparam int IN_BUF_SIZE = 64,
  localparam int OUT_BUF_SIZE = 64
) (
  input  logic                           Clock,
  input  logic                           Reset_n,
  input  logic [NUM_REQ-1:0]             Req,
  input  logic [NUM_REQ*IN_BUF_SIZE-1:0] Din,
  input  logic [NUM_REQ-1:0]             Din_valid,
  input  logic [NUM_REQ-1:0]             Last_block,
  output logic [NUM_REQ-1:0]             Grant,
  output logic [NUM_REQ-1:0]             Din_ready,
  output logic [OUT_BUF_SIZE-1:0]        Dout,
  output logic [NUM_REQ-1:0]             Dout_valid,
  output logic                           Done,
`ifdef KECCAK_ARB_TIMEOUT_EN
  output logic                           Abort,
`endif
  output logic                           Core_start,
  output logic [IN_BUF_SIZE-1:0]         Core_din,
  output logic                           Core_din_valid,
  output logic                           Core_last_block,
  input  logic                           Core_buffer_full,
  input  logic                           Core_ready,
  input  logic [OUT_BUF_SIZE-1:0]        Core_dout,
  input  logic                           Core_dout_valid
);
  localparam int PW = $clog2(NUM_REQ);
  localparam int BW = $clog2(DIGEST_BEATS) + 1;
  localparam logic [2:0] IDLE = 3'd0, START = 3'd1, ABSORB = 3'd2, LASTWAIT = 3'd3, DRAIN = 3'd4;
`ifdef KECCAK_ARB_TIMEOUT_EN
  localparam logic [2:0] START_ABORT = 3'd5;
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
`endif
  logic [2:0] state;
  logic [PW-1:0] ptr, gidx, sel, gnxt;
  logic [NUM_REQ-1:0] grant;
  logic [4:0] wcnt;
  logic [BW-1:0] bcnt;
  logic absorb, drain, core_ok, accept, fwd, last_beat, last_word, timeout;
  assign absorb = state == ABSORB;
  assign drain = state == LASTWAIT || state == DRAIN;
  assign core_ok = Core_ready & ~Core_buffer_full;
  assign accept = absorb & Din_valid[gidx] & core_ok;
  assign last_word = wcnt == 5'(WORDS_PER_BLOCK - 1);
  assign fwd = drain & Core_dout_valid;
  assign last_beat = fwd && bcnt == BW'(DIGEST_BEATS - 1);
  assign gnxt = gidx == PW'(NUM_REQ - 1) ? '0 : gidx + 1'b1;
  assign Grant = grant;
  assign Din_ready = absorb && core_ok ? grant : '0;
  assign Core_din = absorb ? Din[int'(gidx)*IN_BUF_SIZE +: IN_BUF_SIZE] : '0;
  assign Core_din_valid = accept;
  assign Core_last_block = absorb & Last_block[gidx];
  assign Dout = drain ? Core_dout : '0;
  assign Dout_valid = fwd ? grant : '0;
  assign Done = last_beat | timeout;
`ifdef KECCAK_ARB_TIMEOUT_EN
  logic [TW-1:0] tcnt;
  assign timeout = absorb && !Din_valid[gidx] && tcnt == TW'(TIMEOUT_CYCLES - 1);
  assign Abort = timeout;
  assign Core_start = state == START || state == START_ABORT;
  always_ff @(posedge Clock)
    if (!Reset_n || !absorb || accept) tcnt <= '0;
    else if (!Din_valid[gidx]) tcnt <= tcnt + 1'b1;
`else
  assign timeout = 1'b0;
  assign Core_start = state == START;
`endif
  // scan downward so the requester closest to ptr is written last and wins
  always_comb begin
    sel = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--)
      if (Req[(int'(ptr) + k) % NUM_REQ]) sel = PW'((int'(ptr) + k) % NUM_REQ);
  end
  always_ff @(posedge Clock)
    if (!Reset_n) begin
      state <= IDLE;
      ptr <= '0;
      gidx <= '0;
      grant <= '0;
      wcnt <= '0;
      bcnt <= '0;
    end else
      case (state)
        IDLE:
          if (|Req) begin
            state <= START;
            gidx <= sel;
            grant <= NUM_REQ'(1) << sel;
          end
        START: begin
          state <= ABSORB;
          wcnt <= '0;
          bcnt <= '0;
        end
        ABSORB: begin
          if (accept) wcnt <= last_word ? '0 : wcnt + 1'b1;
          if (accept && last_word && Last_block[gidx]) state <= LASTWAIT;
`ifdef KECCAK_ARB_TIMEOUT_EN
          if (timeout) begin
            state <= START_ABORT;
            grant <= '0;
            ptr <= gnxt;
          end
`endif
        end
        LASTWAIT, DRAIN:
          if (fwd) begin
            bcnt <= bcnt + 1'b1;
            state <= last_beat ? IDLE : DRAIN;
            if (last_beat) begin
              grant <= '0;
              ptr <= gnxt;
            end
          end
        default: state <= IDLE;
      endcase
endmodule

// File: tb/tb_keccak_arbiter.sv
// tb_keccak_arbiter: randomized directed bench for keccak_arbiter against a round-robin message model; covers KECCAK_ARB_TIMEOUT_EN when defined
module tb_keccak_arbiter;
  localparam int NR = 2, WPB = 17, DB = 4;
  logic Clock, Reset_n;
  logic [NR-1:0] Req, Din_valid, Last_block, Grant, Din_ready, Dout_valid;
  logic [NR*64-1:0] Din;
  logic [63:0] Dout, Core_din, Core_dout;
  logic Done, Core_start, Core_din_valid, Core_last_block, Core_buffer_full, Core_ready, Core_dout_valid;
`ifdef KECCAK_ARB_TIMEOUT_EN
  logic Abort;
`endif
  int n_assert = 0, n_fail = 0, m_ptr = 0;

  keccak_arbiter #(
    .NUM_REQ(NR), .WORDS_PER_BLOCK(WPB), .DIGEST_BEATS(DB)
`ifdef KECCAK_ARB_TIMEOUT_EN
    , .TIMEOUT_CYCLES(8)
`endif
  ) dut (
    .Clock(Clock), .Reset_n(Reset_n), .Req(Req), .Din(Din), .Din_valid(Din_valid),
    .Last_block(Last_block), .Grant(Grant), .Din_ready(Din_ready), .Dout(Dout),
    .Dout_valid(Dout_valid), .Done(Done),
`ifdef KECCAK_ARB_TIMEOUT_EN
    .Abort(Abort),
`endif
    .Core_start(Core_start), .Core_din(Core_din), .Core_din_valid(Core_din_valid),
    .Core_last_block(Core_last_block), .Core_buffer_full(Core_buffer_full),
    .Core_ready(Core_ready), .Core_dout(Core_dout), .Core_dout_valid(Core_dout_valid)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  task automatic next();
    @(posedge Clock);
    #1;
  endtask

  task automatic settle();
    #3;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] r64();
    return {$urandom, $urandom};
  endfunction

  // round-robin model: first requesting index at or after the model pointer
  function automatic int pick(input logic [NR-1:0] q);
    for (int i = 0; i < NR; i++)
      if (q[(m_ptr + i) % NR]) return (m_ptr + i) % NR;
    return -1;
  endfunction

  task automatic chk_rst(input string tag);
    chk({tag, "_grant"}, Grant, 0);
    chk({tag, "_din_ready"}, Din_ready, 0);
    chk({tag, "_dout_valid"}, Dout_valid, 0);
    chk({tag, "_done"}, Done, 0);
    chk({tag, "_core_start"}, Core_start, 0);
    chk({tag, "_core_din_valid"}, Core_din_valid, 0);
    chk({tag, "_core_last_block"}, Core_last_block, 0);
    chk({tag, "_dout"}, Dout, 0);
    chk({tag, "_core_din"}, Core_din, 0);
`ifdef KECCAK_ARB_TIMEOUT_EN
    chk({tag, "_abort"}, Abort, 0);
`endif
  endtask

  task automatic do_reset(input string tag);
    Reset_n = 1'b0;
    Req = '0;
    Core_dout_valid = 1'b0;
    next();
    settle();
    chk_rst(tag);
    Reset_n = 1'b1;
    m_ptr = 0;
    next();
  endtask

  // One full message; entered at the start of an IDLE cycle with Req already driven,
  // returns at the start of the cycle following Done (or following a mid-drain reset).
  task automatic serve(input int nblk, input int hold, input int rst_beat, input bit drop);
    int r, nw, k, acc, b, guard, hold_cnt;
    logic rdy, full, v;
    logic [63:0] cur;
    r = pick(Req);
    Core_dout_valid = 1'b1;
    Core_dout = r64();
    Din_valid = '1;
    Core_ready = 1'b1;
    Core_buffer_full = 1'b0;
    settle();
    chk("idle_grant", Grant, 0);
    chk("idle_done", Done, 0);
    chk("idle_core_start", Core_start, 0);
    chk("idle_spurious_dout_valid", Dout_valid, 0);
    chk("idle_din_ready", Din_ready, 0);
    next();
    settle();
    chk("grant", Grant, 1 << r);
    chk("core_start", Core_start, 1);
    chk("start_din_ready", Din_ready, 0);
    chk("start_dout_valid", Dout_valid, 0);
    if (drop) Req = '0;
    nw = nblk * WPB;
    k = 0;
    acc = 0;
    hold_cnt = 0;
    guard = 0;
    cur = r64();
    next();
    while (k < nw && guard < 1000) begin
      full = hold_cnt > 0 || $urandom_range(3) == 0;
      rdy = $urandom_range(7) != 0;
      Core_buffer_full = full;
      Core_ready = rdy;
      Din = {r64(), r64()};
      Din[r*64 +: 64] = cur;
      Din_valid = NR'($urandom);
      Din_valid[r] = $urandom_range(3) != 0;
      Last_block = NR'($urandom);
      Last_block[r] = k >= nw - WPB;
      Core_dout_valid = $urandom_range(1) == 1;
      Core_dout = r64();
      settle();
      v = Din_valid[r] & rdy & ~full;
      chk("din_ready", Din_ready, (rdy & ~full) ? (1 << r) : 0);
      chk("core_din_valid", Core_din_valid, v);
      chk("absorb_dout_valid", Dout_valid, 0);
      if (hold_cnt > 0) hold_cnt--;
      if (v) begin
        chk("core_din", Core_din, cur);
        chk("core_last_block", Core_last_block, Last_block[r]);
        k++;
        acc++;
        cur = r64();
        if (hold > 0 && k == WPB) hold_cnt = hold;
      end
      guard++;
      next();
    end
    chk("accepts", acc, nw);
    b = 0;
    guard = 0;
    while (b < DB && guard < 200) begin
      Core_buffer_full = $urandom_range(1) == 1;
      Core_ready = 1'b1;
      Din_valid = '1;
      v = $urandom_range(1) == 1;
      Core_dout_valid = v;
      Core_dout = r64();
      if (rst_beat == b) begin
        Reset_n = 1'b0;
        Req = '0;
        Core_dout_valid = 1'b0;
        next();
        Reset_n = 1'b1;
        settle();
        chk_rst("drain_reset");
        m_ptr = 0;
        next();
        return;
      end
      settle();
      chk("dout_valid", Dout_valid, v ? (1 << r) : 0);
      if (v) chk("dout", Dout, Core_dout);
      chk("done", Done, v && b == DB - 1);
      chk("drain_din_ready", Din_ready, 0);
      chk("drain_core_din_valid", Core_din_valid, 0);
      if (v) b++;
      guard++;
      next();
    end
    chk("beats", b, DB);
    Core_dout_valid = 1'b0;
    m_ptr = (r + 1) % NR;
  endtask

  initial begin
    Reset_n = 1'b0;
    Req = '0;
    Din = '0;
    Din_valid = '0;
    Last_block = '0;
    Core_buffer_full = 1'b0;
    Core_ready = 1'b0;
    Core_dout = '0;
    Core_dout_valid = 1'b0;
    do_reset("reset");
    Req = 2'b01;
    serve(1, 0, -1, 1'b0);
    do_reset("reset2");
    Req = 2'b11;
    serve(1, 0, -1, 1'b0);
    serve(1, 0, -1, 1'b0);
    serve(1, 0, -1, 1'b0);
    Req = 2'b01;
    serve(2, 24, -1, 1'b1);
    Req = 2'b10;
    serve(1, 0, 2, 1'b0);
    Req = 2'b11;
    serve(1, 0, -1, 1'b0);
    for (int i = 0; i < 4; i++) begin
      Req = NR'($urandom_range(3, 1));
      serve($urandom_range(2, 1), 0, -1, 1'b0);
    end
`ifdef KECCAK_ARB_TIMEOUT_EN
    do_reset("reset3");
    Req = 2'b11;
    Core_ready = 1'b1;
    Core_buffer_full = 1'b0;
    Din_valid = '1;
    settle();
    chk("to_idle_grant", Grant, 0);
    next();
    settle();
    chk("to_grant", Grant, 2'b01);
    next();
    for (int i = 0; i < 5; i++) begin
      Din = {r64(), r64()};
      settle();
      chk("to_accept", Core_din_valid, 1);
      next();
    end
    Din_valid = '0;
    for (int i = 1; i <= 8; i++) begin
      settle();
      chk("to_abort", Abort, i == 8);
      chk("to_done", Done, i == 8);
      next();
    end
    settle();
    chk("to_restart", Core_start, 1);
    chk("to_grant_cleared", Grant, 0);
    chk("to_abort_low", Abort, 0);
    next();
    settle();
    chk("to_idle_after", Grant, 0);
    next();
    settle();
    chk("to_next_owner", Grant, 2'b10);
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
